seg7_scan_display: RTL and testbench

//   Parametrised multi-digit hex 7-segment driver, successor to the static per-digit decoder bank.

---
 rtl/seg7_scan_display_if.sv | 23 ++
 rtl/seg7_scan_display.sv | 97 +++++++++
 tb/tb_seg7_scan_display.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if: load/control inputs and display outputs of the scanned 7-segment driver
interface seg7_scan_display_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] iDIG;
    logic                    iLOAD;
    logic                    iBLANK_LZ;
    logic [NUM_DIGITS-1:0]   iBLINK_MASK;
    logic [7*NUM_DIGITS-1:0] oSEG_ALL;
    logic [6:0]              oSEG;
    logic [NUM_DIGITS-1:0]   oDIG_SEL;
    logic                    oACK;
    logic                    oFRAME;

    modport master (
        output iDIG, iLOAD, iBLANK_LZ, iBLINK_MASK,
        input  oSEG_ALL, oSEG, oDIG_SEL, oACK, oFRAME
    );
    modport slave (
        input  iDIG, iLOAD, iBLANK_LZ, iBLINK_MASK,
        output oSEG_ALL, oSEG, oDIG_SEL, oACK, oFRAME
    );
endinterface

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: double-buffered hex 7-segment driver with parallel and scanned outputs
// Staged values commit only at frame boundaries; supports leading-zero blanking and per-digit blink.
module seg7_scan_display #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input logic               iCLK,
    input logic               iRST,
    seg7_scan_display_if.slave bus
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [6:0] BLANK = SEG_ACTIVE_LOW != 0 ? 7'h7F : 7'h00;
    // gfedcba patterns for F..0, digit 0 in the low seven bits
    localparam logic [111:0] FONT = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                     7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

    logic [DW-1:0]           r_div_cnt;
    logic [IW-1:0]           r_idx;
    logic [BW-1:0]           r_blink_cnt;
    logic                    r_phase;
    logic [4*NUM_DIGITS-1:0] r_staging;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic                    r_pending;
    logic                    r_ack;
    logic                    r_frame;
    logic [7*NUM_DIGITS-1:0] r_seg_all;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_dig_sel;
    logic                    w_slot_tick;
    logic                    w_frame_tick;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic [7*NUM_DIGITS-1:0] w_seg_all;
    logic [6:0]              w_seg_cur;

    assign w_slot_tick  = r_div_cnt == DW'(SCAN_DIV - 1);
    assign w_frame_tick = w_slot_tick && r_idx == IW'(NUM_DIGITS - 1);
    assign w_seg_cur    = w_seg_all[7*int'(r_idx) +: 7];

    // w_lz[i]: nibbles i..top of the shadow value are all zero
    always_comb begin
        w_lz = '0;
        w_seg_all = '0;
        w_lz[NUM_DIGITS-1] = r_shadow[4*NUM_DIGITS-1 -: 4] == 4'h0;
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            w_lz[i] = w_lz[i+1] && r_shadow[4*i +: 4] == 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++)
            w_seg_all[7*i +: 7] = ((i != 0 && bus.iBLANK_LZ && w_lz[i]) || (bus.iBLINK_MASK[i] && r_phase)) ? BLANK
                                : SEG_ACTIVE_LOW != 0 ? ~FONT[7*int'(r_shadow[4*i +: 4]) +: 7]
                                : FONT[7*int'(r_shadow[4*i +: 4]) +: 7];
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_div_cnt   <= '0;
            r_idx       <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_staging   <= '0;
            r_shadow    <= '0;
            r_pending   <= 1'b0;
            r_ack       <= 1'b0;
            r_frame     <= 1'b0;
            r_seg_all   <= {NUM_DIGITS{BLANK}};
            r_seg       <= BLANK;
            r_dig_sel   <= '0;
        end else begin
            r_div_cnt <= w_slot_tick ? '0 : r_div_cnt + 1'b1;
            if (w_slot_tick)
                r_idx <= r_idx == IW'(NUM_DIGITS - 1) ? '0 : r_idx + 1'b1;
            if (bus.iLOAD)
                r_staging <= bus.iDIG;
            // a load in the commit cycle keeps pending set for the next frame
            r_pending <= bus.iLOAD || (r_pending && !w_frame_tick);
            if (w_frame_tick && r_pending)
                r_shadow <= r_staging;
            r_ack   <= w_frame_tick && r_pending;
            r_frame <= w_frame_tick;
            if (w_frame_tick) begin
                r_blink_cnt <= r_blink_cnt == BW'(BLINK_FRAMES - 1) ? '0 : r_blink_cnt + 1'b1;
                r_phase     <= r_blink_cnt == BW'(BLINK_FRAMES - 1) ? ~r_phase : r_phase;
            end
            r_seg_all <= w_seg_all;
            r_seg     <= w_seg_cur;
            r_dig_sel <= NUM_DIGITS'(1) << r_idx;
        end
    end

    assign bus.oSEG_ALL = r_seg_all;
    assign bus.oSEG     = r_seg;
    assign bus.oDIG_SEL = r_dig_sel;
    assign bus.oACK     = r_ack;
    assign bus.oFRAME   = r_frame;
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: scoreboarded cycle model plus directed scenario checks for seg7_scan_display
module tb_seg7_scan_display;
    typedef struct {
        logic [55:0] all;
        logic [6:0]  seg;
        logic [7:0]  sel;
        logic        ack;
        logic        frame;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];
    logic [6:0] font[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          m_cyc = 0;
    logic [31:0] m_shadow = '0;
    logic [31:0] m_stage = '0;
    logic        m_pend = 1'b0;

    seg7_scan_display_if #(.NUM_DIGITS(8)) bus ();

    seg7_scan_display #(
        .NUM_DIGITS(8), .SCAN_DIV(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1)
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [55:0] pattern(input logic [31:0] v, input logic ph,
                                            input logic blz, input logic [7:0] mask);
        int msd = 0;
        logic [55:0] r;
        for (int i = 0; i < 8; i++)
            if (v[4*i +: 4] != 4'h0) msd = i;
        for (int i = 0; i < 8; i++)
            r[7*i +: 7] = ((blz && i > msd) || (mask[i] && ph)) ? 7'h7F : ~font[v[4*i +: 4]];
        return r;
    endfunction

    // reference model: expected outputs after each edge are queued at that edge
    always @(posedge clk) begin
        exp_t e;
        int idx;
        logic ftick;
        if (rst) begin
            e = '{all: {8{7'h7F}}, seg: 7'h7F, sel: 8'h00, ack: 1'b0, frame: 1'b0};
            m_cyc    <= 0;
            m_shadow <= '0;
            m_stage  <= '0;
            m_pend   <= 1'b0;
        end else begin
            idx   = (m_cyc / 4) % 8;
            ftick = (m_cyc % 32) == 31;
            e.all   = pattern(m_shadow, ((m_cyc / 32) / 2) % 2 == 1, bus.iBLANK_LZ, bus.iBLINK_MASK);
            e.seg   = e.all[7*idx +: 7];
            e.sel   = 8'h01 << idx;
            e.ack   = ftick && m_pend;
            e.frame = ftick;
            m_cyc  <= m_cyc + 1;
            if (bus.iLOAD) m_stage <= bus.iDIG;
            m_pend <= bus.iLOAD || (m_pend && !ftick);
            if (ftick && m_pend) m_shadow <= m_stage;
        end
        q.push_back(e);
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("sb_seg_all", bus.oSEG_ALL, e.all);
            chk("sb_seg", bus.oSEG, e.seg);
            chk("sb_dig_sel", bus.oDIG_SEL, e.sel);
            chk("sb_ack", bus.oACK, e.ack);
            chk("sb_frame", bus.oFRAME, e.frame);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_val(input logic [31:0] v);
        bus.iDIG  = v;
        bus.iLOAD = 1'b1;
        tick(1);
        bus.iLOAD = 1'b0;
    endtask

    task automatic count_acks(input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            tick(1);
            if (bus.oACK) c++;
        end
    endtask

    initial begin
        int c;
        logic got;
        rst             = 1'b1;
        bus.iDIG        = '0;
        bus.iLOAD       = 1'b0;
        bus.iBLANK_LZ   = 1'b0;
        bus.iBLINK_MASK = '0;
        tick(3);
        chk("rst_seg", bus.oSEG, 7'h7F);
        chk("rst_sel", bus.oDIG_SEL, 8'h00);
        chk("rst_all", bus.oSEG_ALL, {8{7'h7F}});
        rst = 1'b0;
        tick(1);
        chk("first_sel", bus.oDIG_SEL, 8'h01);
        chk("first_seg", bus.oSEG, 7'h40);

        tick(10);
        load_val(32'h1234_5678);
        chk("pre_commit_all", bus.oSEG_ALL, {8{7'h40}});
        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            tick(1);
            if (bus.oACK) got = 1'b1;
        end
        chk("ack_seen", got, 1'b1);
        tick(1);
        chk("commit_d0", bus.oSEG_ALL[6:0], 7'h00);
        chk("commit_d7", bus.oSEG_ALL[55:49], 7'h79);
        count_acks(64, c);
        chk("no_extra_ack", c, 0);

        load_val(32'h1111_1111);
        load_val(32'h2222_2222);
        count_acks(70, c);
        chk("last_wins_acks", c, 1);
        chk("last_wins_all", bus.oSEG_ALL, {8{7'h24}});

        bus.iBLANK_LZ = 1'b1;
        load_val(32'h0000_00A0);
        count_acks(70, c);
        chk("lz_a0", bus.oSEG_ALL, {{6{7'h7F}}, 7'h08, 7'h40});
        load_val(32'h0000_0000);
        count_acks(70, c);
        chk("lz_zero", bus.oSEG_ALL, {{7{7'h7F}}, 7'h40});
        bus.iBLANK_LZ = 1'b0;

        rst = 1'b1;
        bus.iBLINK_MASK = 8'h01;
        tick(2);
        rst = 1'b0;
        tick(17);
        for (int f = 0; f < 6; f++) begin
            chk($sformatf("blink_f%0d", f), bus.oSEG_ALL,
                {{7{7'h40}}, (f == 2 || f == 3) ? 7'h7F : 7'h40});
            if (f < 5) tick(32);
        end
        bus.iBLINK_MASK = 8'h00;

        got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            tick(1);
            if (bus.oFRAME) got = 1'b1;
        end
        chk("frame_seen", got, 1'b1);
        c = 0;
        got = 1'b0;
        while (!got && c < 64) begin
            tick(1);
            c++;
            if (bus.oFRAME) got = 1'b1;
        end
        chk("frame_period", c, 32);

        load_val(32'hDEAD_BEEF);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        count_acks(70, c);
        chk("rst_drop_acks", c, 0);
        chk("rst_drop_all", bus.oSEG_ALL, {8{7'h40}});
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
